// File: rtl/pwm2wheel_cmd_if.sv
// Signal bundle for the PWM-to-wheel-command decoder.
// The master side drives the PWM input and controls; the slave side is the decoder.
interface pwm2wheel_cmd_if;
  logic        enable;
  logic        one_MHz_enable;
  logic [3:0]  speed;
  logic        pwm_in;
  logic [3:0]  wheel_cmd;
  logic        cmd_valid;
  logic [11:0] pulse_width_us;
  logic        pulse_err;
  logic        signal_lost;

  modport master (
    output enable, one_MHz_enable, speed, pwm_in,
    input  wheel_cmd, cmd_valid, pulse_width_us, pulse_err, signal_lost
  );

  modport slave (
    input  enable, one_MHz_enable, speed, pwm_in,
    output wheel_cmd, cmd_valid, pulse_width_us, pulse_err, signal_lost
  );
endinterface

// File: rtl/pwm2wheel_cmd.sv
// Decodes a servo-style PWM pulse back into a signed 4-bit wheel command (sequential divider).
// Optional feature macro: PWM_DEADBAND_EN (center deadband of DEADBAND_US forces a zero command).
module pwm2wheel_cmd #(
  parameter int unsigned CENTER_US   = 1500,
  parameter int unsigned STEP_US     = 10,
  parameter int unsigned MIN_US      = 1000,
  parameter int unsigned MAX_US      = 2000,
  parameter int unsigned TIMEOUT_US  = 25000,
  parameter int unsigned DEADBAND_US = 30
) (
  input  logic            clk,
  input  logic            reset_n,
  pwm2wheel_cmd_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HIGH   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_DIVIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [11:0] MIN_W    = 12'(MIN_US);
  localparam logic [11:0] MAX_W    = 12'(MAX_US);
  localparam logic [12:0] CENTER_W = 13'(CENTER_US);
  localparam logic [14:0] TO_W     = 15'(TIMEOUT_US);
  localparam logic [12:0] DB_W     = 13'(DEADBAND_US);

  state_t      state_q;
  logic        pwm_meta_q;
  logic        pwm_sync_q;
  logic        pwm_prev_q;
  logic [11:0] width_q;
  logic [14:0] to_cnt_q;
  logic [14:0] to_cnt_d;
  logic [12:0] mag_q;
  logic        neg_q;
  logic [11:0] div_q;
  logic [3:0]  quo_q;
  logic [3:0]  wheel_cmd_q;
  logic        cmd_valid_q;
  logic [11:0] pulse_width_q;
  logic        pulse_err_q;
  logic        signal_lost_q;

  logic        rise_s;
  logic        timeout_s;
  logic [11:0] width_inc_s;
  logic [12:0] delta_s;
  logic        delta_neg_s;
  logic [12:0] mag_s;
  logic        legal_s;
  logic [11:0] divisor_s;
  logic [3:0]  q_lim_s;
  logic        div_stop_s;

`ifndef PWM_DEADBAND_EN
  logic unused_db_s;
  assign unused_db_s = ^DB_W;
`endif

  // Edge detection, timeout counting and division arithmetic
  always_comb begin
    rise_s      = pwm_sync_q & ~pwm_prev_q;
    width_inc_s = (width_q == 12'hFFF) ? width_q : (width_q + 12'd1);
    delta_s     = {1'b0, width_q} - CENTER_W;
    delta_neg_s = delta_s[12];
    mag_s       = delta_neg_s ? (13'd0 - delta_s) : delta_s;
    legal_s     = (width_q >= MIN_W) && (width_q <= MAX_W);
    divisor_s   = 12'(bus.speed) * 12'(STEP_US);
    q_lim_s     = neg_q ? 4'd8 : 4'd7;
    div_stop_s  = (div_q == 12'd0) || (quo_q == q_lim_s) || (mag_q < {1'b0, div_q});
    timeout_s   = ~rise_s & bus.one_MHz_enable & (to_cnt_q == (TO_W - 15'd1));
    if (rise_s) begin
      to_cnt_d = 15'd0;
    end else if (bus.one_MHz_enable && (to_cnt_q != TO_W)) begin
      to_cnt_d = to_cnt_q + 15'd1;
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Synchronizer, measurement FSM, divider and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pwm_meta_q    <= 1'b0;
      pwm_sync_q    <= 1'b0;
      pwm_prev_q    <= 1'b0;
      width_q       <= 12'd0;
      to_cnt_q      <= 15'd0;
      mag_q         <= 13'd0;
      neg_q         <= 1'b0;
      div_q         <= 12'd0;
      quo_q         <= 4'd0;
      wheel_cmd_q   <= 4'd0;
      cmd_valid_q   <= 1'b0;
      pulse_width_q <= 12'd0;
      pulse_err_q   <= 1'b0;
      signal_lost_q <= 1'b0;
    end else begin
      pwm_meta_q  <= bus.pwm_in;
      pwm_sync_q  <= pwm_meta_q;
      pwm_prev_q  <= pwm_sync_q;
      cmd_valid_q <= 1'b0;
      if (!bus.enable) begin
        state_q  <= ST_IDLE;
        width_q  <= 12'd0;
        to_cnt_q <= 15'd0;
      end else begin
        to_cnt_q <= to_cnt_d;
        if (rise_s) begin
          signal_lost_q <= 1'b0;
        end
        // Timeout overrides whatever the FSM was doing, including a pulse stuck high
        if (timeout_s) begin
          signal_lost_q <= 1'b1;
          wheel_cmd_q   <= 4'd0;
          cmd_valid_q   <= 1'b1;
          state_q       <= ST_IDLE;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (rise_s) begin
                width_q <= bus.one_MHz_enable ? 12'd1 : 12'd0;
                state_q <= ST_HIGH;
              end
            end
            ST_HIGH: begin
              if (!pwm_sync_q) begin
                state_q <= ST_CHECK;
              end else if (bus.one_MHz_enable) begin
                width_q <= width_inc_s;
              end
            end
            ST_CHECK: begin
              if (!legal_s) begin
                pulse_err_q <= 1'b1;
                state_q     <= ST_IDLE;
              end else begin
                pulse_err_q   <= 1'b0;
                pulse_width_q <= width_q;
                mag_q         <= mag_s;
                neg_q         <= delta_neg_s;
                div_q         <= divisor_s;
                quo_q         <= 4'd0;
`ifdef PWM_DEADBAND_EN
                state_q       <= (mag_s < DB_W) ? ST_DONE : ST_DIVIDE;
`else
                state_q       <= ST_DIVIDE;
`endif
              end
            end
            ST_DIVIDE: begin
              if (div_stop_s) begin
                state_q <= ST_DONE;
              end else begin
                mag_q <= mag_q - {1'b0, div_q};
                quo_q <= quo_q + 4'd1;
              end
            end
            ST_DONE: begin
              wheel_cmd_q <= neg_q ? (4'd0 - quo_q) : quo_q;
              cmd_valid_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
            default: begin
              state_q <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign bus.wheel_cmd      = wheel_cmd_q;
  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.pulse_width_us = pulse_width_q;
  assign bus.pulse_err      = pulse_err_q;
  assign bus.signal_lost    = signal_lost_q;

endmodule

// File: tb/tb_pwm2wheel_cmd.sv
// Self-checking bench for pwm2wheel_cmd: directed cases plus random pulses against an arithmetic model.
module tb_pwm2wheel_cmd;

  logic clk = 1'b0;
  logic reset_n;

  pwm2wheel_cmd_if bus ();

  pwm2wheel_cmd dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam int GAP = 40;

  int n_pass    = 0;
  int n_fail    = 0;
  int n_total   = 0;
  int valid_cnt = 0;
  int tick_div  = 1;
  int phase     = 0;
  int exp_cmd   = 0;
  int exp_w     = 0;
  logic exp_err = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs just after the edge, then set the us tick for the next edge
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.cmd_valid === 1'b1) valid_cnt++;
    if (phase >= tick_div - 1) begin
      bus.one_MHz_enable = 1'b1;
      phase = 0;
    end else begin
      bus.one_MHz_enable = 1'b0;
      phase++;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Command implied by a legal pulse width: truncating divide, then saturate
  function automatic int model_cmd(input int w, input int spd);
    int d;
    int m;
    int q;
    d = w - 1500;
    m = (d < 0) ? -d : d;
`ifdef PWM_DEADBAND_EN
    if (m < 30) return 0;
`endif
    if (spd == 0) return 0;
    q = m / (spd * 10);
    if (d >= 0 && q > 7) q = 7;
    if (d < 0 && q > 8) q = 8;
    return (d < 0) ? -q : q;
  endfunction

  task automatic check_outputs(input string tag);
    logic [3:0] ec;
    ec = 4'(exp_cmd);
    check({tag, ".wheel_cmd"}, 16'(bus.wheel_cmd), 16'(ec));
    check({tag, ".width"}, 16'(bus.pulse_width_us), 16'(exp_w));
    check({tag, ".pulse_err"}, 16'(bus.pulse_err), 16'(exp_err));
  endtask

  // Drive one pulse of w microseconds at speed spd and check the decode against the model
  task automatic run_pulse(input string tag, input int w, input int spd);
    int  v0;
    bit  legal;
    v0 = valid_cnt;
    bus.speed  = 4'(spd);
    bus.pwm_in = 1'b1;
    steps(w * tick_div);
    bus.pwm_in = 1'b0;
    steps(GAP);
    legal = (w >= 1000) && (w <= 2000);
    if (legal) begin
      exp_cmd = model_cmd(w, spd);
      exp_w   = w;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    check({tag, ".valid_cnt"}, 16'(valid_cnt - v0), legal ? 16'd1 : 16'd0);
    check_outputs(tag);
    check({tag, ".signal_lost"}, 16'(bus.signal_lost), 16'd0);
  endtask

  initial begin
    int v0;
    int w;
    int s;
    reset_n            = 1'b0;
    bus.enable         = 1'b1;
    bus.one_MHz_enable = 1'b1;
    bus.speed          = 4'd2;
    bus.pwm_in         = 1'b0;
    steps(5);
    check("reset.cmd_valid", 16'(bus.cmd_valid), 16'd0);
    check("reset.signal_lost", 16'(bus.signal_lost), 16'd0);
    check_outputs("reset");
    reset_n = 1'b1;
    steps(10);

    run_pulse("c1500", 1500, 2);
    run_pulse("c1560", 1560, 2);
    run_pulse("c1340", 1340, 2);
    run_pulse("c1700", 1700, 2);
    run_pulse("c1519", 1519, 2);
    run_pulse("b1000", 1000, 2);
    run_pulse("b2000", 2000, 2);
    run_pulse("b999", 999, 2);
    run_pulse("b2001", 2001, 2);
    run_pulse("pre_err", 1560, 2);
    run_pulse("e900", 900, 2);
    run_pulse("clr_err", 1500, 2);

    run_pulse("pre_to", 1560, 2);
    v0 = valid_cnt;
    steps(23000);
    check("to.early_lost", 16'(bus.signal_lost), 16'd0);
    check("to.early_valid", 16'(valid_cnt - v0), 16'd0);
    steps(3000);
    exp_cmd = 0;
    check("to.lost", 16'(bus.signal_lost), 16'd1);
    check("to.valid_once", 16'(valid_cnt - v0), 16'd1);
    check("to.wheel_cmd", 16'(bus.wheel_cmd), 16'd0);
    run_pulse("relock", 1560, 2);

    bus.pwm_in = 1'b1;
    steps(500);
    reset_n    = 1'b0;
    bus.pwm_in = 1'b0;
    steps(5);
    exp_cmd = 0;
    exp_w   = 0;
    exp_err = 1'b0;
    check_outputs("midrst");
    check("midrst.signal_lost", 16'(bus.signal_lost), 16'd0);
    reset_n = 1'b1;
    steps(20);
    run_pulse("post_rst", 1560, 2);
    run_pulse("spd0", 1700, 0);
    run_pulse("spd1_1525", 1525, 1);

    v0 = valid_cnt;
    bus.pwm_in = 1'b1;
    steps(800);
    bus.enable = 1'b0;
    steps(5);
    bus.pwm_in = 1'b0;
    steps(5);
    bus.enable = 1'b1;
    steps(GAP);
    check("en_abort.valid_cnt", 16'(valid_cnt - v0), 16'd0);
    check_outputs("en_abort");

    tick_div = 3;
    phase    = 0;
    run_pulse("div3", 1620, 3);
    tick_div = 1;
    phase    = 0;

    for (int i = 0; i < 5; i++) begin
      w = int'($urandom_range(2050, 950));
      s = int'($urandom_range(15, 0));
      run_pulse($sformatf("rnd%0d_w%0d_s%0d", i, w, s), w, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
